gpr_file: RTL and testbench
===========================

// Module: gpr_file
// PURPOSE
//   General-purpose register file: write-back end of the EXU srd / gpr_w_en interface.
//   Provides two zero-latency read ports (src1/src2) with same-cycle write bypass.
//   Provides one synchronous write port; x0 is hard-wired to zero.
//   Keeps a per-register pending scoreboard for multi-cycle loads so the decoder can
//   stall on read-after-write hazards.
// PARAMETERS
//   ISA_WIDTH       32  data width of each register
//   REG_NUM         32  implemented registers (16 for RV32E); index >= REG_NUM reads 0
//   REG_ADDR_WIDTH  5   register index width
// PORTS
//   clk            in   1               rising-edge clock
//   rst            in   1               asynchronous reset, active-low
//   rs1_addr       in   REG_ADDR_WIDTH  read port 1 index
//   rs2_addr       in   REG_ADDR_WIDTH  read port 2 index
//   src1           out  ISA_WIDTH       read port 1 data
//   src2           out  ISA_WIDTH       read port 2 data
//   rd_addr        in   REG_ADDR_WIDTH  write index
//   srd            in   ISA_WIDTH       write data
//   gpr_w_en       in   1               write enable
//   pend_set_en    in   1               mark pend_set_addr as pending (load issued)
//   pend_set_addr  in   REG_ADDR_WIDTH  register to mark pending
//   rs1_busy       out  1               rs1 is pending and not resolved this cycle
//   rs2_busy       out  1               rs2 is pending and not resolved this cycle
//   pend_any       out  1               OR of all pending bits
// BEHAVIOUR
//   State
//   - regs[REG_NUM] of ISA_WIDTH bits; busy[REG_NUM] of 1 bit.
//   Reset
//   - rst low forces all regs = 0 and all busy = 0 immediately (asynchronous).
//   - Reset is allowed mid-operation; outstanding pending marks are discarded.
//   - Resulting outputs: src1 = src2 = 0, rs*_busy = 0, pend_any = 0.
//   - Internal state is set only by rst, not by any input combination.
//   Write
//   - At posedge clk, if gpr_w_en && rd_addr != 0 && rd_addr < REG_NUM: regs[rd_addr] <= srd.
//   - All other writes (index 0, out-of-range index, or gpr_w_en low) are dropped silently.
//   Read (combinational, 0-cycle latency), for each port with address A:
//   - A == 0 or A >= REG_NUM -> 0.
//   - else if gpr_w_en && rd_addr == A -> srd (write-first bypass).
//   - else -> regs[A].
//   Scoreboard, per register i != 0, i < REG_NUM, updated at posedge clk:
//   - set_i = pend_set_en && pend_set_addr == i.
//   - clr_i = gpr_w_en && rd_addr == i.
//   - set_i takes priority: busy[i] <= 1.
//   - else if clr_i: busy[i] <= 0.
//   - Set and clear on the same index in the same cycle leaves the index pending.
//     The new load supersedes the retiring one; the data write still happens.
//   - Set on index 0 or an out-of-range index is ignored; busy[0] is constantly 0.
//   Busy outputs
//   - rsN_busy = busy[A] && !(gpr_w_en && rd_addr == A); always 0 for A == 0.
//   - The bypass resolves the hazard in the same cycle as the write.
//   - pend_any = |busy (registered state, no bypass).
//   No handshake back-pressure; the caller must not issue a second load to a busy rd
//   unless it intends supersede semantics.
// TESTING
//   1. Reset, then read every index -> all 0, no busy, pend_any = 0.
//   2. Write x5 = 32'hDEADBEEF; same cycle rs1_addr = 5 -> src1 = DEADBEEF (bypass).
//      Next cycle it still reads DEADBEEF.
//   3. Write x0 = 32'h1234 -> src1 at rs1_addr = 0 reads 0 on both cycles.
//   4. pend_set x7 -> next cycle rs2_busy = 1 and pend_any = 1.
//      Then write x7 = 32'h55 -> that cycle rs2_busy = 0 and src2 = 55.
//      Next cycle pend_any = 0.
//   5. x7 busy; same cycle pend_set x7 and write x7 = 32'hAA -> next cycle x7 reads AA
//      and rs1_busy = 1 (set wins).
//   6. REG_NUM = 16: write x20 = 32'h1; pend_set x20 -> reads 0, busy 0, pend_any 0.
//      Additional case: assert rst low while x3 is busy -> busy clears with no clock edge.

Source files
------------

// File: rtl/gpr_file.sv
// ---------------------------------------------------------------------------
// gpr_file
//   General-purpose register file at the write-back end of the EXU.
//   - Two combinational read ports (src1/src2) with write-first bypass.
//   - One synchronous write port (rd_addr/srd/gpr_w_en); x0 reads as zero.
//   - A per-register pending scoreboard that marks registers targeted by
//     in-flight multi-cycle loads, so the decoder can stall on RAW hazards.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active-low
//   rs1_addr       read port 1 index
//   rs2_addr       read port 2 index
//   src1, src2     read data (0 for x0 and for indexes >= REG_NUM)
//   rd_addr        write index
//   srd            write data
//   gpr_w_en       write enable
//   pend_set_en    mark pend_set_addr as pending (load issued)
//   pend_set_addr  register to mark pending
//   rs1_busy       rs1 pending and not resolved by a write this cycle
//   rs2_busy       rs2 pending and not resolved by a write this cycle
//   pend_any       OR of all pending bits (registered state only)
//
// Interface semantics: there is no valid/ready handshake on this block. A
// write is accepted on every clock edge where gpr_w_en is high; a pending
// mark is accepted on every edge where pend_set_en is high. The caller owns
// hazard avoidance; a second load to a busy register supersedes the first.
// ---------------------------------------------------------------------------
module gpr_file #(
    parameter int ISA_WIDTH      = 32,
    parameter int REG_NUM        = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [ISA_WIDTH-1:0]      src1,
    output logic [ISA_WIDTH-1:0]      src2,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic [ISA_WIDTH-1:0]      srd,
    input  logic                      gpr_w_en,
    input  logic                      pend_set_en,
    input  logic [REG_ADDR_WIDTH-1:0] pend_set_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      pend_any
);

    logic [ISA_WIDTH-1:0] regs [REG_NUM];
    logic [REG_NUM-1:0]   busy;

    // Write and set decode. Loops start at 1 and stop below REG_NUM, so
    // writes/sets to x0 or to unimplemented indexes never match anything.
    logic [REG_NUM-1:0] wr_hit;
    logic [REG_NUM-1:0] set_hit;

    always_comb begin
        wr_hit  = '0;
        set_hit = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            wr_hit[i]  = gpr_w_en && (rd_addr == REG_ADDR_WIDTH'(i));
            set_hit[i] = pend_set_en && (pend_set_addr == REG_ADDR_WIDTH'(i));
        end
    end

    // Register array and scoreboard. Entry 0 is only ever loaded by reset,
    // so it stays zero (and busy[0] stays clear) for the life of the part.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (wr_hit[i]) begin
                    regs[i] <= srd;
                end
                // A new load issued in the same cycle the old one retires
                // keeps the register pending: the newer load owns it.
                if (set_hit[i]) begin
                    busy[i] <= 1'b1;
                end else if (wr_hit[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Read ports. A same-cycle write to the addressed register is forwarded
    // and also resolves its pending hazard.
    logic rs1_bypass;
    logic rs2_bypass;

    assign rs1_bypass = gpr_w_en && (rd_addr == rs1_addr);
    assign rs2_bypass = gpr_w_en && (rd_addr == rs2_addr);

    always_comb begin
        src1     = '0;
        src2     = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 1; i < REG_NUM; i++) begin
            if (rs1_addr == REG_ADDR_WIDTH'(i)) begin
                src1     = rs1_bypass ? srd : regs[i];
                rs1_busy = busy[i] && !rs1_bypass;
            end
            if (rs2_addr == REG_ADDR_WIDTH'(i)) begin
                src2     = rs2_bypass ? srd : regs[i];
                rs2_busy = busy[i] && !rs2_bypass;
            end
        end
    end

    assign pend_any = |busy;

endmodule

// File: tb/tb_gpr_file.sv
// ---------------------------------------------------------------------------
// tb_gpr_file
//   Directed bench for gpr_file. Two instances share every input: u32 is the
//   full RV32I file (REG_NUM = 32), u16 is the RV32E file (REG_NUM = 16) used
//   for the out-of-range index cases.
// ---------------------------------------------------------------------------
module tb_gpr_file;

    localparam int W  = 32;
    localparam int AW = 5;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus
    logic [AW-1:0] rs1_addr      = '0;
    logic [AW-1:0] rs2_addr      = '0;
    logic [AW-1:0] rd_addr       = '0;
    logic [W-1:0]  srd           = '0;
    logic          gpr_w_en      = 1'b0;
    logic          pend_set_en   = 1'b0;
    logic [AW-1:0] pend_set_addr = '0;

    // Outputs of each instance
    logic [W-1:0] a_src1, a_src2, b_src1, b_src2;
    logic         a_rs1_busy, a_rs2_busy, a_pend_any;
    logic         b_rs1_busy, b_rs2_busy, b_pend_any;

    int checks = 0;
    int errors = 0;

    gpr_file #(.ISA_WIDTH(W), .REG_NUM(32), .REG_ADDR_WIDTH(AW)) u32 (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .src1(a_src1), .src2(a_src2),
        .rd_addr(rd_addr), .srd(srd), .gpr_w_en(gpr_w_en),
        .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
        .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy), .pend_any(a_pend_any)
    );

    gpr_file #(.ISA_WIDTH(W), .REG_NUM(16), .REG_ADDR_WIDTH(AW)) u16 (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .src1(b_src1), .src2(b_src2),
        .rd_addr(rd_addr), .srd(srd), .gpr_w_en(gpr_w_en),
        .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy), .pend_any(b_pend_any)
    );

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        gpr_w_en    = 1'b0;
        pend_set_en = 1'b0;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        gpr_w_en = 1'b1;
        rd_addr  = a;
        srd      = d;
    endtask

    task automatic drive_pend(input logic [AW-1:0] a);
        pend_set_en   = 1'b1;
        pend_set_addr = a;
    endtask

    // Comparison point
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. Reset held: every index reads 0, nothing busy.
        rst = 1'b0;
        #2;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'(31 - i);
            #1;
            check($sformatf("rst_src1[%0d]", i), a_src1, 32'h0);
            check($sformatf("rst_src2[%0d]", 31 - i), a_src2, 32'h0);
            check($sformatf("rst_busy1[%0d]", i), {31'b0, a_rs1_busy}, 32'h0);
            check($sformatf("rst_busy2[%0d]", i), {31'b0, a_rs2_busy}, 32'h0);
        end
        check("rst_pend_any", {31'b0, a_pend_any}, 32'h0);
        check("rst_pend_any16", {31'b0, b_pend_any}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 2. Write x5 with same-cycle bypass, then registered read.
        next_cycle();
        drive_write(5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5;
        #1;
        check("x5_bypass", a_src1, 32'hDEADBEEF);
        next_cycle();
        idle();
        #1;
        check("x5_stored", a_src1, 32'hDEADBEEF);

        // 3. Write to x0 is dropped on both cycles; x5 untouched.
        drive_write(5'd0, 32'h1234);
        rs1_addr = 5'd0;
        rs2_addr = 5'd5;
        #1;
        check("x0_bypass", a_src1, 32'h0);
        next_cycle();
        idle();
        #1;
        check("x0_stored", a_src1, 32'h0);
        check("x5_kept", a_src2, 32'hDEADBEEF);

        // 4. Pending mark on x7, then resolved by the load write-back.
        drive_pend(5'd7);
        rs2_addr = 5'd7;
        #1;
        check("x7_busy_before_edge", {31'b0, a_rs2_busy}, 32'h0);
        next_cycle();
        idle();
        #1;
        check("x7_busy", {31'b0, a_rs2_busy}, 32'h1);
        check("x7_pend_any", {31'b0, a_pend_any}, 32'h1);
        drive_write(5'd7, 32'h55);
        #1;
        check("x7_busy_resolved", {31'b0, a_rs2_busy}, 32'h0);
        check("x7_src2_bypass", a_src2, 32'h55);
        check("x7_pend_any_still", {31'b0, a_pend_any}, 32'h1);
        next_cycle();
        idle();
        #1;
        check("x7_pend_any_clear", {31'b0, a_pend_any}, 32'h0);
        check("x7_src2_stored", a_src2, 32'h55);

        // 5. Set and clear x7 in the same cycle: data lands, set wins.
        drive_pend(5'd7);
        next_cycle();
        drive_pend(5'd7);
        drive_write(5'd7, 32'hAA);
        rs1_addr = 5'd7;
        #1;
        check("x7_supersede_bypass", a_src1, 32'hAA);
        check("x7_supersede_busy_now", {31'b0, a_rs1_busy}, 32'h0);
        next_cycle();
        idle();
        #1;
        check("x7_supersede_data", a_src1, 32'hAA);
        check("x7_supersede_busy", {31'b0, a_rs1_busy}, 32'h1);
        check("x7_supersede_pend_any", {31'b0, a_pend_any}, 32'h1);

        // Retire the superseding load so both files start clean.
        drive_write(5'd7, 32'hAA);
        next_cycle();
        idle();
        #1;
        check("clean_pend_any", {31'b0, a_pend_any}, 32'h0);
        check("clean_pend_any16", {31'b0, b_pend_any}, 32'h0);

        // 6. Index 20 is out of range for the 16-entry file.
        drive_write(5'd20, 32'h1);
        drive_pend(5'd20);
        rs1_addr = 5'd20;
        #1;
        check("x20_16_bypass", b_src1, 32'h0);
        check("x20_16_busy_now", {31'b0, b_rs1_busy}, 32'h0);
        check("x20_32_bypass", a_src1, 32'h1);
        next_cycle();
        idle();
        #1;
        check("x20_16_read", b_src1, 32'h0);
        check("x20_16_busy", {31'b0, b_rs1_busy}, 32'h0);
        check("x20_16_pend_any", {31'b0, b_pend_any}, 32'h0);
        check("x20_32_read", a_src1, 32'h1);
        check("x20_32_busy", {31'b0, a_rs1_busy}, 32'h1);
        check("x20_32_pend_any", {31'b0, a_pend_any}, 32'h1);

        // Asynchronous reset mid-operation while x3 is pending.
        drive_pend(5'd3);
        rs1_addr = 5'd3;
        rs2_addr = 5'd5;
        next_cycle();
        idle();
        #1;
        check("x3_busy", {31'b0, a_rs1_busy}, 32'h1);
        check("x3_busy16", {31'b0, b_rs1_busy}, 32'h1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, a_rs1_busy}, 32'h0);
        check("async_rst_busy16", {31'b0, b_rs1_busy}, 32'h0);
        check("async_rst_pend_any", {31'b0, a_pend_any}, 32'h0);
        check("async_rst_pend_any16", {31'b0, b_pend_any}, 32'h0);
        check("async_rst_x5", a_src2, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
